// File: rtl/eth_tx_gap_ctrl.sv
// GMII transmit gate: registers the merged arbiter stream, enforces the inter-frame gap,
// truncates jabber frames and blocks while the link is down. Define ETH_TX_STAT_EN for counters.
module eth_tx_gap_ctrl #(
  parameter int IFG_CYCLES = 12,
  parameter int MAX_LEN    = 1530,
  parameter int LEN_W      = 11
) (
  input  logic        gmii_clk,
  input  logic        rst_n,
  input  logic [7:0]  in_gmii_txd,
  input  logic        in_gmii_tx_en,
  input  logic        in_gmii_tx_er,
  input  logic        link_up,
  output logic        ready,
  output logic [7:0]  gmii_txd,
  output logic        gmii_tx_en,
  output logic        gmii_tx_er,
  output logic [1:0]  tx_state_dbg,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam int GAP_W = $clog2(IFG_CYCLES);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(IFG_CYCLES - 1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);

  state_t             state;
  logic [LEN_W-1:0]   byte_cnt;
  logic [GAP_W-1:0]   gap_cnt;

  assign tx_state_dbg = state;

  // Handshake: ready is a frame-start permission only. The arbiter samples it when it
  // raises in_gmii_tx_en; after that every byte is consumed on every cycle regardless of ready.
  always_ff @(posedge gmii_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      byte_cnt   <= '0;
      gap_cnt    <= '0;
      ready      <= 1'b0;
      gmii_txd   <= 8'd0;
      gmii_tx_en <= 1'b0;
      gmii_tx_er <= 1'b0;
    end else begin
      gmii_txd   <= 8'd0;
      gmii_tx_en <= 1'b0;
      gmii_tx_er <= 1'b0;
      ready      <= 1'b0;
      case (state)
        IDLE: begin
          if (in_gmii_tx_en) begin
            if (link_up) begin
              state      <= PASS;
              byte_cnt   <= LEN_W'(1);
              gmii_txd   <= in_gmii_txd;
              gmii_tx_en <= 1'b1;
              gmii_tx_er <= in_gmii_tx_er;
            end else begin
              state <= DROP;
            end
          end else begin
            ready <= link_up;
          end
        end
        PASS: begin
          if (!in_gmii_tx_en) begin
            state   <= GAP;
            gap_cnt <= GAP_LOAD;
          end else if (byte_cnt == LEN_MAX || !link_up) begin
            // Replace the offending byte with an error marker so the PHY aborts the frame.
            state      <= DROP;
            gmii_tx_en <= 1'b1;
            gmii_tx_er <= 1'b1;
          end else begin
            byte_cnt   <= byte_cnt + 1'b1;
            gmii_txd   <= in_gmii_txd;
            gmii_tx_en <= 1'b1;
            gmii_tx_er <= in_gmii_tx_er;
          end
        end
        DROP: begin
          if (!in_gmii_tx_en) begin
            state   <= GAP;
            gap_cnt <= GAP_LOAD;
          end
        end
        GAP: begin
          if (in_gmii_tx_en) begin
            state <= DROP;
          end else if (gap_cnt == '0) begin
            state <= IDLE;
            ready <= link_up;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ETH_TX_STAT_EN
  logic bad;
  logic good_end;
  logic bad_end;

  always_comb begin
    good_end = (state == PASS) && !in_gmii_tx_en && !bad;
    bad_end  = ((state == PASS) && !in_gmii_tx_en && bad) ||
               ((state == DROP) && !in_gmii_tx_en);
  end

  // Frame status follows the same conditions that steer the FSM into DROP or flag tx_er.
  always_ff @(posedge gmii_clk or negedge rst_n) begin
    if (!rst_n) begin
      bad       <= 1'b0;
      frame_cnt <= 16'd0;
      err_cnt   <= 16'd0;
    end else begin
      case (state)
        IDLE: if (in_gmii_tx_en) bad <= in_gmii_tx_er || !link_up;
        PASS: if (in_gmii_tx_en) bad <= bad || in_gmii_tx_er || !link_up || (byte_cnt == LEN_MAX);
        GAP:  if (in_gmii_tx_en) bad <= 1'b1;
        default: bad <= bad;
      endcase
      if (good_end && frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'd1;
      if (bad_end && err_cnt != 16'hFFFF)    err_cnt   <= err_cnt + 16'd1;
    end
  end
`else
  assign frame_cnt = 16'd0;
  assign err_cnt   = 16'd0;
`endif

endmodule

// File: tb/tb_eth_tx_gap_ctrl.sv
// Bench for eth_tx_gap_ctrl: scenario table, hand-written corner sequences and random
// streams checked against a frame-level reference model.
module tb_eth_tx_gap_ctrl;

  localparam int IFG  = 12;
  localparam int MAXL = 1530;
  localparam int NMAX = 4000;
`ifdef ETH_TX_STAT_EN
  localparam bit STAT_EN = 1'b1;
`else
  localparam bit STAT_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic        gmii_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_gmii_txd = 8'd0;
  logic        in_gmii_tx_en = 1'b0;
  logic        in_gmii_tx_er = 1'b0;
  logic        link_up = 1'b1;
  logic        ready;
  logic [7:0]  gmii_txd;
  logic        gmii_tx_en;
  logic        gmii_tx_er;
  logic [1:0]  tx_state_dbg;
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;

  always #5 gmii_clk = ~gmii_clk;

  eth_tx_gap_ctrl #(
    .IFG_CYCLES(IFG),
    .MAX_LEN(MAXL),
    .LEN_W(11)
  ) dut (
    .gmii_clk(gmii_clk),
    .rst_n(rst_n),
    .in_gmii_txd(in_gmii_txd),
    .in_gmii_tx_en(in_gmii_tx_en),
    .in_gmii_tx_er(in_gmii_tx_er),
    .link_up(link_up),
    .ready(ready),
    .gmii_txd(gmii_txd),
    .gmii_tx_en(gmii_tx_en),
    .gmii_tx_er(gmii_tx_er),
    .tx_state_dbg(tx_state_dbg),
    .frame_cnt(frame_cnt),
    .err_cnt(err_cnt)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // ---------------- stimulus / expectation storage ----------------
  typedef struct {
    bit         en;
    bit         er;
    bit         link;
    logic [7:0] d;
  } stim_t;

  typedef struct {
    bit         en;
    bit         er;
    bit         rdy;
    logic [7:0] d;
    logic [1:0] st;
    int         fc;
    int         ec;
  } exp_t;

  typedef struct {
    int len;
    int er_pos;
    int drop_pos;
    int drop_len;
    int exp_fwd;
    int exp_marker;
    int exp_er_out;
    int exp_frames;
    int exp_errs;
    int exp_rdy_low;
  } vec_t;

  stim_t stim[NMAX];
  exp_t  expv[NMAX];
  bit    ev_good[NMAX];
  bit    ev_bad[NMAX];
  int    n_cyc;

  // Outputs sampled 1 time unit after each rising edge.
  logic [7:0]  o_d;
  logic        o_en, o_er, o_rdy;
  logic [1:0]  o_st;
  logic [15:0] o_fc, o_ec;

  int agg_fwd, agg_marker, agg_er, agg_data_err, agg_first, agg_rdy_low;

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n         = 1'b0;
    in_gmii_tx_en = 1'b0;
    in_gmii_tx_er = 1'b0;
    in_gmii_txd   = 8'd0;
    link_up       = 1'b1;
    @(negedge gmii_clk);
    @(negedge gmii_clk);
    rst_n = 1'b1;
  endtask

  task automatic drive_cycle(input bit en, input logic [7:0] d, input bit er, input bit link);
    in_gmii_tx_en = en;
    in_gmii_txd   = d;
    in_gmii_tx_er = er;
    link_up       = link;
    @(posedge gmii_clk);
    #1;
    o_d   = gmii_txd;
    o_en  = gmii_tx_en;
    o_er  = gmii_tx_er;
    o_rdy = ready;
    o_st  = tx_state_dbg;
    o_fc  = frame_cnt;
    o_ec  = err_cnt;
    @(negedge gmii_clk);
  endtask

  // ---------------- reference model ----------------
  // Works on whole frames (maximal runs of tx_en): a frame is accepted only if it starts
  // at least IFG+1 cycles after the previous frame ended and the link is up at its start;
  // accepted frames are copied with one cycle latency until byte MAXL+1 or a link drop.
  task automatic build_expect();
    int  t, s, e, fwd, good_n, bad_n, free_at;
    bit  bad;
    for (int i = 0; i < n_cyc; i++) begin
      expv[i].en = 0; expv[i].er = 0; expv[i].d = 8'd0; expv[i].st = 2'd0;
      expv[i].rdy = 0; expv[i].fc = 0; expv[i].ec = 0;
      ev_good[i] = 0; ev_bad[i] = 0;
    end
    free_at = 0;
    t = 0;
    while (t < n_cyc) begin
      if (!stim[t].en) begin
        t++;
        continue;
      end
      s = t;
      e = t;
      while (e < n_cyc && stim[e].en) e++;
      bad = (s < free_at) || !stim[s].link;
      fwd = 0;
      if (!bad) begin
        for (int i = 1; i <= e - s; i++) begin
          int k;
          k = s + i - 1;
          if (i == MAXL + 1 || !stim[k].link) begin
            expv[k].en = 1; expv[k].er = 1; expv[k].d = 8'd0;
            bad = 1;
            break;
          end
          expv[k].en = 1; expv[k].er = stim[k].er; expv[k].d = stim[k].d;
          if (stim[k].er) bad = 1;
          fwd = i;
        end
      end
      for (int k = s; k < e; k++) expv[k].st = (k < s + fwd) ? 2'd1 : 2'd2;
      for (int k = e; k < e + IFG && k < n_cyc; k++) expv[k].st = 2'd3;
      if (e < n_cyc) begin
        if (bad) ev_bad[e] = 1;
        else     ev_good[e] = 1;
      end
      free_at = e + IFG + 1;
      t = e;
    end
    good_n = 0;
    bad_n  = 0;
    for (int k = 0; k < n_cyc; k++) begin
      if (ev_good[k]) good_n++;
      if (ev_bad[k])  bad_n++;
      expv[k].fc  = STAT_EN ? good_n : 0;
      expv[k].ec  = STAT_EN ? bad_n : 0;
      expv[k].rdy = (expv[k].st == 2'd0) && stim[k].link;
    end
  endtask

  // Applies stim[0..n_cyc-1] after a reset and compares every cycle with the model.
  task automatic run_stream(input string name);
    int    bad_cyc;
    string msg;
    bad_cyc = 0;
    msg = "";
    build_expect();
    do_reset();
    agg_fwd = 0; agg_marker = 0; agg_er = 0; agg_data_err = 0; agg_first = -1; agg_rdy_low = 0;
    for (int t = 0; t < n_cyc; t++) begin
      drive_cycle(stim[t].en, stim[t].d, stim[t].er, stim[t].link);
      if (o_en !== expv[t].en || o_er !== expv[t].er || o_d !== expv[t].d ||
          o_rdy !== expv[t].rdy || o_st !== expv[t].st ||
          o_fc !== 16'(expv[t].fc) || o_ec !== 16'(expv[t].ec)) begin
        if (bad_cyc == 0)
          msg = $sformatf("  %s first differing cycle %0d: got en=%0b er=%0b d=%02h rdy=%0b st=%0d fc=%0d ec=%0d; want en=%0b er=%0b d=%02h rdy=%0b st=%0d fc=%0d ec=%0d",
                          name, t, o_en, o_er, o_d, o_rdy, o_st, o_fc, o_ec,
                          expv[t].en, expv[t].er, expv[t].d, expv[t].rdy, expv[t].st,
                          expv[t].fc, expv[t].ec);
        bad_cyc++;
      end
      if (o_en && o_er && o_d == 8'd0) begin
        agg_marker++;
      end else if (o_en) begin
        agg_fwd++;
        if (agg_first < 0) agg_first = t;
        if (o_er) agg_er++;
        if (o_d != 8'((agg_fwd % 255) + 1)) agg_data_err++;
      end
      if (!o_rdy) agg_rdy_low++;
    end
    check({name, " cycles differing from model"}, bad_cyc, 0);
    if (bad_cyc != 0) $display("%s", msg);
  endtask

  // ---------------- stimulus builders ----------------
  task automatic clear_stim(input int n);
    for (int t = 0; t < NMAX; t++) begin
      stim[t].en = 0; stim[t].er = 0; stim[t].link = 1; stim[t].d = 8'd0;
    end
    n_cyc = n;
  endtask

  // Frame starts at edge 3; byte i carries (i % 255) + 1 so data is never zero.
  task automatic build_table_stim(input vec_t v);
    clear_stim(3 + v.len + 60);
    for (int i = 1; i <= v.len; i++) begin
      stim[2 + i].en = 1;
      stim[2 + i].d  = 8'((i % 255) + 1);
      stim[2 + i].er = (i == v.er_pos);
    end
    if (v.drop_pos > 0)
      for (int j = 0; j < v.drop_len; j++) stim[2 + v.drop_pos + j].link = 0;
  endtask

  task automatic build_random_stim(input int target);
    int t, g, len, long_left;
    clear_stim(target + 2 * IFG + 30);
    t = 0;
    long_left = 1;
    while (t < target) begin
      case ($urandom_range(0, 5))
        0:       g = $urandom_range(0, 3);
        1:       g = IFG - 1;
        2:       g = IFG;
        3:       g = IFG + 1;
        default: g = $urandom_range(0, 30);
      endcase
      if (long_left > 0 && $urandom_range(0, 19) == 0) begin
        len = $urandom_range(MAXL - 4, MAXL + 4);
        long_left--;
      end else begin
        len = $urandom_range(1, 70);
      end
      t += g;
      for (int i = 0; i < len && t < target; i++) begin
        stim[t].en = 1;
        stim[t].d  = 8'($urandom_range(0, 255));
        stim[t].er = ($urandom_range(0, 49) == 0);
        t++;
      end
    end
    for (int k = 0; k < target; k++) begin
      if ($urandom_range(0, 249) == 0) begin
        int run;
        run = $urandom_range(1, 20);
        for (int j = 0; j < run && k + j < target; j++) stim[k + j].link = 0;
      end
    end
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[9];

  initial begin
    int idle_out, leak, w;
    //         len  erp drp dln  fwd  mk er fr er  rdylow
    vecs[0] = '{64,   0,  0,  0,  64, 0, 0, 1, 0,   76};
    vecs[1] = '{1600, 0,  0,  0, 1530, 1, 0, 0, 1, 1612};
    vecs[2] = '{100, 20,  0,  0, 100, 0, 1, 0, 1,  112};
    vecs[3] = '{100,  0, 30, 20,  29, 1, 0, 0, 1,  112};
    vecs[4] = '{10,   0,  1, 40,   0, 0, 0, 0, 1,   40};
    vecs[5] = '{1,    0,  0,  0,   1, 0, 0, 1, 0,   13};
    vecs[6] = '{1530, 0,  0,  0, 1530, 0, 0, 1, 0, 1542};
    vecs[7] = '{1531, 0,  0,  0, 1530, 1, 0, 0, 1, 1543};
    vecs[8] = '{64,   1,  0,  0,  64, 0, 1, 0, 1,   76};

    // Reset values while rst_n is held low.
    @(negedge gmii_clk);
    @(negedge gmii_clk);
    check("reset ready", ready, 0);
    check("reset gmii_txd", gmii_txd, 0);
    check("reset gmii_tx_en", gmii_tx_en, 0);
    check("reset gmii_tx_er", gmii_tx_er, 0);
    check("reset tx_state_dbg", tx_state_dbg, 0);
    check("reset frame_cnt", frame_cnt, 0);
    check("reset err_cnt", err_cnt, 0);

    // Table-driven frame scenarios.
    foreach (vecs[i]) begin
      string nm;
      nm = $sformatf("vec%0d len%0d", i, vecs[i].len);
      build_table_stim(vecs[i]);
      run_stream(nm);
      check({nm, " forwarded bytes"}, agg_fwd, vecs[i].exp_fwd);
      check({nm, " truncation markers"}, agg_marker, vecs[i].exp_marker);
      check({nm, " tx_er bytes out"}, agg_er, vecs[i].exp_er_out);
      check({nm, " data errors"}, agg_data_err, 0);
      if (vecs[i].exp_fwd > 0) check({nm, " first output cycle"}, agg_first, 3);
      check({nm, " ready low cycles"}, agg_rdy_low, vecs[i].exp_rdy_low);
      check({nm, " frame_cnt"}, o_fc, STAT_EN ? vecs[i].exp_frames : 0);
      check({nm, " err_cnt"}, o_ec, STAT_EN ? vecs[i].exp_errs : 0);
    end

    // Asynchronous reset in the middle of a frame forces idle outputs at once.
    do_reset();
    drive_cycle(0, 8'd0, 0, 1);
    for (int i = 1; i <= 5; i++) drive_cycle(1, 8'(i + 16), 0, 1);
    check("mid-frame tx_en before reset", o_en, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset gmii_tx_en", gmii_tx_en, 0);
    check("async reset gmii_txd", gmii_txd, 0);
    check("async reset tx_state_dbg", tx_state_dbg, 0);
    check("async reset ready", ready, 0);

    // Arbiter restarting as soon as ready is seen: output gap must be IFG+1.
    do_reset();
    drive_cycle(0, 8'd0, 0, 1);
    for (int i = 1; i <= 64; i++) drive_cycle(1, 8'(i), 0, 1);
    idle_out = 0;
    w = 0;
    while (!o_rdy && w < 100) begin
      drive_cycle(0, 8'd0, 0, 1);
      if (!o_en) idle_out++;
      w++;
    end
    check("back-to-back ready returned", o_rdy, 1);
    drive_cycle(1, 8'h5A, 0, 1);
    check("back-to-back second frame accepted", o_en, 1);
    check("back-to-back output idle gap", idle_out, IFG + 1);
    for (int i = 2; i <= 64; i++) drive_cycle(1, 8'(i), 0, 1);
    drive_cycle(0, 8'd0, 0, 1);
    check("back-to-back frame_cnt", o_fc, STAT_EN ? 2 : 0);

    // Frame restarted three cycles into the gap is dropped and the gap restarts.
    do_reset();
    drive_cycle(0, 8'd0, 0, 1);
    for (int i = 1; i <= 20; i++) drive_cycle(1, 8'(i), 0, 1);
    idle_out = 0;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(0, 8'd0, 0, 1);
      if (!o_en) idle_out++;
    end
    leak = 0;
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1, 8'hA5, 0, 1);
      if (o_en) leak++;
      else idle_out++;
    end
    check("gap restart bytes leaked", leak, 0);
    check("gap restart state", o_st, 2);
    w = 0;
    while (!o_rdy && w < 200) begin
      drive_cycle(0, 8'd0, 0, 1);
      if (!o_en) idle_out++;
      w++;
    end
    check("gap restart ready returned", o_rdy, 1);
    drive_cycle(1, 8'h11, 0, 1);
    check("gap restart next frame accepted", o_en, 1);
    check("gap restart idle before next frame >= 13", (idle_out >= IFG + 1), 1);
    for (int i = 2; i <= 10; i++) drive_cycle(1, 8'(i), 0, 1);
    drive_cycle(0, 8'd0, 0, 1);
    check("gap restart frame_cnt", o_fc, STAT_EN ? 2 : 0);
    check("gap restart err_cnt", o_ec, STAT_EN ? 1 : 0);

    // Random streams against the reference model.
    for (int r = 0; r < 3; r++) begin
      build_random_stim(2500);
      run_stream($sformatf("random%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
